// File: rtl/cascade_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cascade_counter_pkg
// Brief   : Shared defaults and digit-width helper for the cascade counter.
// Revision: 1.0
// ============================================================================
package cascade_counter_pkg;

    // Smallest digit width able to hold values 0..modulus-1.
    function automatic int digit_width(input int modulus);
        int w;
        w = 1;
        while ((1 << w) < modulus) begin
            w++;
        end
        return w;
    endfunction

    localparam int DEF_DIGITS  = 2;
    localparam int DEF_MODULUS = 10;
    localparam int DEF_DIGIT_W = digit_width(DEF_MODULUS);

endpackage : cascade_counter_pkg
`default_nettype wire

// File: rtl/cascade_counter_mod_digit.sv
`default_nettype none
// ============================================================================
// Module  : mod_digit
// Brief   : One modulo-MODULUS digit with clear, load, increment and decrement.
// Revision: 1.0
// ============================================================================
module mod_digit
    import cascade_counter_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_val,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [DIGIT_W-1:0] o_val,
    output logic               o_at_max,
    output logic               o_at_zero
);

    localparam logic [DIGIT_W-1:0] c_MAX = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] r_val;
    logic               w_load_ok;

    // Compare in 32 bits so MODULUS == 2**DIGIT_W does not truncate.
    assign w_load_ok = (32'(i_load_val) < 32'(MODULUS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= '0;
        end else if (i_clear) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= w_load_ok ? i_load_val : '0;
        end else if (i_inc) begin
            r_val <= o_at_max ? '0 : r_val + 1'b1;
        end else if (i_dec) begin
            r_val <= o_at_zero ? c_MAX : r_val - 1'b1;
        end
    end

    assign o_val     = r_val;
    assign o_at_max  = (r_val == c_MAX);
    assign o_at_zero = (r_val == '0);

endmodule : mod_digit
`default_nettype wire

// File: rtl/cascade_counter.sv
`default_nettype none
// ============================================================================
// Module  : cascade_counter
// Brief   : DIGITS-digit up/down cascaded modulo counter with tc and wrap.
// Revision: 1.0
// ============================================================================
module cascade_counter
    import cascade_counter_pkg::*;
#(
    parameter int DIGITS  = DEF_DIGITS,
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_en,
    input  logic                      io_up,
    input  logic                      io_clear,
    input  logic                      io_load,
    input  logic [DIGITS*DIGIT_W-1:0] io_load_val,
    output logic [DIGITS*DIGIT_W-1:0] io_count,
    output logic                      io_tc,
    output logic                      io_wrap
);

    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_zero;
    logic [DIGITS-1:0] w_inc;
    logic [DIGITS-1:0] w_dec;
    logic              w_step;
    logic              w_all_max;
    logic              w_all_zero;
    logic              w_wrap_now;
    logic              r_wrap;

    // Counting happens only when neither clear nor load owns this edge.
    assign w_step = io_en & ~io_clear & ~io_load;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            // Bits at and above k forced to 1 so only lower digits matter.
            localparam logic [DIGITS-1:0] c_LO_MASK = DIGITS'((64'd1 << k) - 64'd1);

            assign w_inc[k] = w_step &  io_up & (&(w_at_max  | ~c_LO_MASK));
            assign w_dec[k] = w_step & ~io_up & (&(w_at_zero | ~c_LO_MASK));

            mod_digit #(
                .DIGIT_W (DIGIT_W),
                .MODULUS (MODULUS)
            ) u_digit (
                .clk        (clock),
                .rst_n      (reset),
                .i_clear    (io_clear),
                .i_load     (io_load),
                .i_load_val (io_load_val[k*DIGIT_W +: DIGIT_W]),
                .i_inc      (w_inc[k]),
                .i_dec      (w_dec[k]),
                .o_val      (io_count[k*DIGIT_W +: DIGIT_W]),
                .o_at_max   (w_at_max[k]),
                .o_at_zero  (w_at_zero[k])
            );
        end
    endgenerate

    assign w_all_max  = &w_at_max;
    assign w_all_zero = &w_at_zero;
    assign io_tc      = io_up ? w_all_max : w_all_zero;
    assign w_wrap_now = w_step & io_tc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_now;
        end
    end

    assign io_wrap = r_wrap;

endmodule : cascade_counter
`default_nettype wire

// File: tb/tb_cascade_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cascade_counter
// Brief   : Directed self-checking bench for cascade_counter (2 x mod-10).
// Revision: 1.0
// ============================================================================
module tb_cascade_counter;

    logic       clock;
    logic       reset;
    logic       io_en;
    logic       io_up;
    logic       io_clear;
    logic       io_load;
    logic [7:0] io_load_val;
    logic [7:0] io_count;
    logic       io_tc;
    logic       io_wrap;

    int total;
    int bad;

    cascade_counter #(
        .DIGITS  (2),
        .DIGIT_W (4),
        .MODULUS (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_en       (io_en),
        .io_up       (io_up),
        .io_clear    (io_clear),
        .io_load     (io_load),
        .io_load_val (io_load_val),
        .io_count    (io_count),
        .io_tc       (io_tc),
        .io_wrap     (io_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic do_load(input logic [7:0] v);
        io_load = 1'b1; io_load_val = v; io_en = 1'b0; io_clear = 1'b0;
        step();
        io_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; io_en = 1'b0; io_up = 1'b1; io_clear = 1'b0;
        io_load = 1'b0; io_load_val = 8'h00;
        #12;
        total++;
        if (io_count !== 8'h00) begin
            bad++; $display("FAIL reset_count got=%h exp=00", io_count);
        end
        total++;
        if (io_wrap !== 1'b0) begin
            bad++; $display("FAIL reset_wrap got=%b exp=0", io_wrap);
        end
        total++;
        if (io_tc !== 1'b0) begin
            bad++; $display("FAIL reset_tc_up got=%b exp=0", io_tc);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_count_up();
        int c;
        int wraps;
        int errs;
        c = 0; wraps = 0; errs = 0;
        io_en = 1'b1; io_up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            total++;
            if (io_tc !== (c == 99)) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL up_tc at=%0d got=%b exp=%b", c, io_tc, (c == 99));
            end
            step();
            total++;
            if (io_count !== bcd((c + 1) % 100) || io_wrap !== (c == 99)) begin
                bad++; errs++;
                if (errs < 5) $display("FAIL up_step from=%0d got=%h/%b exp=%h/%b",
                                       c, io_count, io_wrap, bcd((c + 1) % 100), (c == 99));
            end
            if (io_wrap === 1'b1) wraps++;
            c = (c + 1) % 100;
        end
        total++;
        if (wraps != 1) begin
            bad++; $display("FAIL up_wrap_count got=%0d exp=1", wraps);
        end
        io_en = 1'b0;
        step();
        total++;
        if (io_wrap !== 1'b0) begin
            bad++; $display("FAIL up_wrap_one_cycle got=%b exp=0", io_wrap);
        end
    endtask

    task automatic test_load_step();
        do_load(8'h09);
        io_en = 1'b1; io_up = 1'b1;
        step();
        total++;
        if (io_count !== 8'h10 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL carry_09_up got=%h/%b exp=10/0", io_count, io_wrap);
        end
        do_load(8'h10);
        io_en = 1'b1; io_up = 1'b0;
        step();
        total++;
        if (io_count !== 8'h09 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL borrow_10_down got=%h/%b exp=09/0", io_count, io_wrap);
        end
        io_en = 1'b0;
    endtask

    task automatic test_down_wrap();
        io_clear = 1'b1; io_en = 1'b0;
        step();
        io_clear = 1'b0; io_up = 1'b0;
        #1;
        total++;
        if (io_tc !== 1'b1) begin
            bad++; $display("FAIL down_tc_at_00 got=%b exp=1", io_tc);
        end
        io_en = 1'b1;
        step();
        total++;
        if (io_count !== 8'h99 || io_wrap !== 1'b1) begin
            bad++; $display("FAIL down_wrap got=%h/%b exp=99/1", io_count, io_wrap);
        end
        total++;
        if (io_tc !== 1'b0) begin
            bad++; $display("FAIL down_tc_at_99 got=%b exp=0", io_tc);
        end
        step();
        total++;
        if (io_count !== 8'h98 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL down_after_wrap got=%h/%b exp=98/0", io_count, io_wrap);
        end
        io_en = 1'b0;
    endtask

    task automatic test_priority();
        do_load(8'h42);
        io_clear = 1'b1; io_load = 1'b1; io_load_val = 8'h55; io_en = 1'b1; io_up = 1'b1;
        step();
        total++;
        if (io_count !== 8'h00 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL clear_wins got=%h/%b exp=00/0", io_count, io_wrap);
        end
        io_clear = 1'b0;
        step();
        total++;
        if (io_count !== 8'h55 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL load_over_en got=%h/%b exp=55/0", io_count, io_wrap);
        end
        do_load(8'h99);
        io_load = 1'b1; io_load_val = 8'h00; io_en = 1'b1; io_up = 1'b1;
        step();
        total++;
        if (io_count !== 8'h00 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL load_no_wrap got=%h/%b exp=00/0", io_count, io_wrap);
        end
        io_load = 1'b0; io_en = 1'b0;
    endtask

    task automatic test_illegal_load();
        int errs;
        errs = 0;
        do_load(8'hAF);
        total++;
        if (io_count !== 8'h00) begin
            bad++; $display("FAIL load_AF got=%h exp=00", io_count);
        end
        do_load(8'h7C);
        total++;
        if (io_count !== 8'h70) begin
            bad++; $display("FAIL load_7C got=%h exp=70", io_count);
        end
        io_en = 1'b0; io_up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (io_count !== 8'h70) begin
                bad++; errs++;
                if (errs < 3) $display("FAIL hold cyc=%0d got=%h exp=70", i, io_count);
            end
        end
    endtask

    task automatic test_async_reset();
        do_load(8'h37);
        total++;
        if (io_count !== 8'h37) begin
            bad++; $display("FAIL load_37 got=%h exp=37", io_count);
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (io_count !== 8'h00 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL async_reset_37 got=%h/%b exp=00/0", io_count, io_wrap);
        end
        #2;
        reset = 1'b1;
        step();
        do_load(8'h99);
        io_en = 1'b1; io_up = 1'b1;
        step();
        io_en = 1'b0;
        total++;
        if (io_count !== 8'h00 || io_wrap !== 1'b1) begin
            bad++; $display("FAIL pre_reset_wrap got=%h/%b exp=00/1", io_count, io_wrap);
        end
        #3;
        reset = 1'b0; io_up = 1'b0;
        #1;
        total++;
        if (io_wrap !== 1'b0 || io_tc !== 1'b1) begin
            bad++; $display("FAIL async_reset_wrap got=%b/%b exp=0/1", io_wrap, io_tc);
        end
        #2;
        reset = 1'b1; io_up = 1'b1; io_en = 1'b1;
        step();
        total++;
        if (io_count !== 8'h01 || io_wrap !== 1'b0) begin
            bad++; $display("FAIL resume got=%h/%b exp=01/0", io_count, io_wrap);
        end
        io_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_count_up();
        test_load_step();
        test_down_wrap();
        test_priority();
        test_illegal_load();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cascade_counter
`default_nettype wire
